// File: rtl/uart_cmd_framer.sv
// Assembles UART bytes into 3-byte command frames (opcode, addr, data), validates
// the opcode and presents each frame on a valid/ready interface with error pulses.
module uart_cmd_framer #(
    parameter int         TO_BITS    = 16,
    parameter logic [7:0] CMD_PING   = 8'h01,
    parameter logic [7:0] CMD_WRITE  = 8'h02,
    parameter logic [7:0] CMD_READ   = 8'h03,
    parameter logic [7:0] CMD_RUN    = 8'h04,
    parameter logic [7:0] CMD_HALT   = 8'h05,
    parameter logic [7:0] CMD_STEP   = 8'h06,
    parameter logic [7:0] CMD_SET_PC = 8'h07,
    parameter logic [7:0] CMD_GET_PC = 8'h08
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TO_BITS-1:0] timeout_cyc,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [2:0]         cmd_op,
    output logic [7:0]         cmd_addr,
    output logic [7:0]         cmd_data,
    output logic               err_opcode,
    output logic               err_timeout,
    output logic               err_overrun,
    output logic               busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_ISSUE = 2'd3;

    localparam logic [TO_BITS-1:0] CNT_ONE = TO_BITS'(1);
    localparam logic [TO_BITS-1:0] CNT_MAX = '1;

    // Returns {known, op_index}; op_index is 0 when the opcode is unknown.
    function automatic logic [3:0] decode_op(input logic [7:0] b);
        logic [3:0] res;
        res = 4'b0000;
        case (b)
            CMD_PING:   res = 4'b1000;
            CMD_WRITE:  res = 4'b1001;
            CMD_READ:   res = 4'b1010;
            CMD_RUN:    res = 4'b1011;
            CMD_HALT:   res = 4'b1100;
            CMD_STEP:   res = 4'b1101;
            CMD_SET_PC: res = 4'b1110;
            CMD_GET_PC: res = 4'b1111;
            default:    res = 4'b0000;
        endcase
        return res;
    endfunction

    logic [1:0]         r_state;
    logic [7:0]         r_opcode;
    logic               r_opc_ok;
    logic [2:0]         r_op;
    logic [7:0]         r_addr;
    logic [7:0]         r_data;
    logic [TO_BITS-1:0] r_idle_cnt;
    logic               r_err_opcode;
    logic               r_err_timeout;
    logic               r_err_overrun;

    logic [3:0]         w_rx_dec;
    logic [3:0]         w_lat_dec;
    logic               w_expired;

    assign w_rx_dec  = decode_op(rx_data);
    assign w_lat_dec = decode_op(r_opcode);
    // Expiry cycle: counter shows timeout_cyc completed idle cycles; a byte here still wins.
    assign w_expired = (timeout_cyc != '0) && (r_idle_cnt == timeout_cyc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_opcode      <= 8'h00;
            r_opc_ok      <= 1'b0;
            r_op          <= 3'd0;
            r_addr        <= 8'h00;
            r_data        <= 8'h00;
            r_idle_cnt    <= '0;
            r_err_opcode  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_opcode  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idle_cnt <= '0;
                    if (rx_valid) begin
                        r_opcode <= rx_data;
                        r_opc_ok <= w_rx_dec[3];
                        r_state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        r_addr     <= rx_data;
                        r_idle_cnt <= '0;
                        r_state    <= S_DATA;
                    end else if (w_expired) begin
                        r_err_timeout <= 1'b1;
                        r_idle_cnt    <= '0;
                        r_state       <= S_IDLE;
                    end else if (r_idle_cnt != CNT_MAX) begin
                        r_idle_cnt <= r_idle_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_data     <= rx_data;
                        r_idle_cnt <= '0;
                        if (r_opc_ok) begin
                            r_op    <= w_lat_dec[2:0];
                            r_state <= S_ISSUE;
                        end else begin
                            r_err_opcode <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end else if (w_expired) begin
                        r_err_timeout <= 1'b1;
                        r_idle_cnt    <= '0;
                        r_state       <= S_IDLE;
                    end else if (r_idle_cnt != CNT_MAX) begin
                        r_idle_cnt <= r_idle_cnt + CNT_ONE;
                    end
                end
                S_ISSUE: begin
                    r_idle_cnt <= '0;
                    // A byte coinciding with the handshake starts the next frame.
                    if (cmd_ready) begin
                        if (rx_valid) begin
                            r_opcode <= rx_data;
                            r_opc_ok <= w_rx_dec[3];
                            r_state  <= S_ADDR;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (rx_valid) begin
                        r_err_overrun <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid   = (r_state == S_ISSUE);
    assign busy        = (r_state != S_IDLE);
    assign cmd_op      = r_op;
    assign cmd_addr    = r_addr;
    assign cmd_data    = r_data;
    assign err_opcode  = r_err_opcode;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;

endmodule
